// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
//
// 8N1 serial receiver, LSB first. The raw line is brought into the clk domain
// through a two-flop synchronizer. A start edge arms a bit-timing counter that
// samples each bit at its midpoint. Completed bytes are presented on a
// data/valid/ready handshake and held until the consumer accepts them.
//
// Parameters:
//   BAUD_DIV     clk cycles per serial bit (>= 4)
//
// Ports:
//   clk          system clock
//   clr          synchronous, active-high reset
//   rx           asynchronous serial line, idle high
//   data[7:0]    received byte, stable while valid is high
//   valid        byte available
//   ready        consumer accepts data when valid && ready at a posedge
//   framing_err  one-cycle pulse: stop bit sampled low
//   overrun      one-cycle pulse: byte completed while previous one unaccepted
// ---------------------------------------------------------------------------
module uart_rx #(
   parameter int BAUD_DIV = 217
) (
   input  logic       clk,
   input  logic       clr,
   input  logic       rx,
   output logic [7:0] data,
   output logic       valid,
   input  logic       ready,
   output logic       framing_err,
   output logic       overrun
);

   localparam int HALF = BAUD_DIV / 2;
   localparam int CW   = $clog2(BAUD_DIV);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      WAIT_HIGH
   } state_t;

   state_t          state, state_nxt;
   logic [CW-1:0]   cnt, cnt_nxt;
   logic [2:0]      bit_idx, bit_idx_nxt;
   logic [7:0]      shreg;
   logic            rx_m, rx_s;
   logic            shift_en;
   logic            load_byte;
   logic            ovr_set;
   logic            ferr_set;

   // ------------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------------
   // NOTE: sequential state is written with non-blocking assignments so every
   // flop samples the pre-edge values, independent of block ordering.
   always_ff @(posedge clk) begin
      if (clr) begin
         state   <= IDLE;
         cnt     <= '0;
         bit_idx <= '0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         bit_idx <= bit_idx_nxt;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state logic. The counter runs free while a frame is in progress and
   // wraps to 0 on every sample, so START waits HALF cycles from the edge and
   // every later bit waits a full BAUD_DIV.
   // ------------------------------------------------------------------------
   // NOTE: every output of this block gets a default first; a path that left
   // one unassigned would infer a latch.
   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt + 1'b1;
      bit_idx_nxt = bit_idx;
      shift_en    = 1'b0;
      load_byte   = 1'b0;
      ovr_set     = 1'b0;
      ferr_set    = 1'b0;

      case (state)
         IDLE: begin
            cnt_nxt = '0;
            if (!rx_s) begin
               state_nxt   = START;
               bit_idx_nxt = '0;
            end
         end

         START: begin
            if (cnt == CW'(HALF - 1)) begin
               cnt_nxt = '0;
               if (!rx_s) begin
                  state_nxt   = DATA;
                  bit_idx_nxt = '0;
               end else begin
                  // Line went back high before mid-start: a glitch, not a frame.
                  state_nxt = IDLE;
               end
            end
         end

         DATA: begin
            if (cnt == CW'(BAUD_DIV - 1)) begin
               cnt_nxt     = '0;
               shift_en    = 1'b1;
               bit_idx_nxt = bit_idx + 3'd1;
               if (bit_idx == 3'd7) state_nxt = STOP;
            end
         end

         STOP: begin
            if (cnt == CW'(BAUD_DIV - 1)) begin
               cnt_nxt = '0;
               if (rx_s) begin
                  // A byte accepted in this same cycle frees the holding slot.
                  if (!valid || ready) load_byte = 1'b1;
                  else                 ovr_set   = 1'b1;
                  // Re-entering IDLE at mid-stop leaves HALF cycles of margin
                  // before a back-to-back start edge can arrive.
                  state_nxt = IDLE;
               end else begin
                  ferr_set  = 1'b1;
                  state_nxt = WAIT_HIGH;
               end
            end
         end

         WAIT_HIGH: begin
            // A break or stuck-low line must not be read as start bits.
            cnt_nxt = '0;
            if (rx_s) state_nxt = IDLE;
         end

         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Synchronizer, shift register and output holding register
   // ------------------------------------------------------------------------
   // NOTE: everything here is reset, including the shift register; it is only
   // a handful of flops and a known value keeps data=0 after clr.
   always_ff @(posedge clk) begin
      if (clr) begin
         rx_m        <= 1'b1;
         rx_s        <= 1'b1;
         shreg       <= '0;
         data        <= '0;
         valid       <= 1'b0;
         framing_err <= 1'b0;
         overrun     <= 1'b0;
      end else begin
         rx_m        <= rx;
         rx_s        <= rx_m;
         framing_err <= ferr_set;
         overrun     <= ovr_set;

         if (shift_en) shreg <= {rx_s, shreg[7:1]};

         if (load_byte) begin
            data  <= shreg;
            valid <= 1'b1;
         end else if (valid && ready) begin
            valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx
//
// Directed bench for uart_rx with BAUD_DIV=16. Bytes that should be delivered
// are pushed into a scoreboard queue when their frame is driven; a monitor
// pops and compares whenever the DUT hands a byte over (valid && ready).
// ---------------------------------------------------------------------------
module tb_uart_rx;

   localparam int BAUD = 16;
   localparam int HALF = BAUD / 2;
   // Raw rx fall -> valid high: 2 synchronizer cycles + HALF + 9 bits + 1.
   localparam int LAT  = 2 + HALF + 9 * BAUD + 1;

   logic       clk = 1'b0;
   logic       clr = 1'b1;
   logic       rx = 1'b1;
   logic       ready = 1'b0;
   logic [7:0] data;
   logic       valid;
   logic       framing_err;
   logic       overrun;

   uart_rx #(.BAUD_DIV(BAUD)) dut (
      .clk         (clk),
      .clr         (clr),
      .rx          (rx),
      .data        (data),
      .valid       (valid),
      .ready       (ready),
      .framing_err (framing_err),
      .overrun     (overrun)
   );

   always #5 clk = ~clk;

   int         vectors = 0;
   int         miscompares = 0;
   logic [7:0] exp_q[$];
   int         cyc = 0;
   int         fall_cyc = 0;
   int         rise_cyc = 0;
   int         valid_cycles = 0;
   int         ferr_cnt = 0;
   int         ovr_cnt = 0;
   logic       valid_d = 1'b0;
   bit         toggle_rdy = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Monitor: sample away from the active edge.
   always @(negedge clk) begin
      if (!clr) begin
         if (valid && !valid_d) rise_cyc <= cyc;
         if (valid)       valid_cycles <= valid_cycles + 1;
         if (framing_err) ferr_cnt <= ferr_cnt + 1;
         if (overrun)     ovr_cnt <= ovr_cnt + 1;
         if (valid && ready) begin
            check("byte_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) check("rx_data", 32'(data), 32'(exp_q.pop_front()));
         end
      end
      valid_d <= valid;
   end

   task automatic tick();
      @(posedge clk);
      #1;
      if (toggle_rdy) ready = ~ready;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   // Drive one 8N1 frame. clr_bit >= 0 pulses clr mid-way through that bit.
   task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                             input bit push, input int clr_bit);
      logic bitv;
      if (push) exp_q.push_back(b);
      for (int k = 0; k < 10; k++) begin
         if (k == 0)      bitv = 1'b0;
         else if (k == 9) bitv = stop_bit;
         else             bitv = b[k-1];
         for (int c = 0; c < BAUD; c++) begin
            tick();
            if (c == 0) rx = bitv;
            if (k == 0 && c == 0) fall_cyc = cyc;
            if (k == clr_bit && c == 8) clr = 1'b1;
            if (k == clr_bit && c == 9) begin
               clr = 1'b0;
               @(negedge clk);
               check("clr_valid", 32'(valid), 32'd0);
               check("clr_data", 32'(data), 32'd0);
            end
         end
      end
   endtask

   int v0, f0, o0;

   initial begin
      // Reset
      idle(2);
      clr = 1'b0;
      @(negedge clk);
      check("rst_data", 32'(data), 32'd0);
      check("rst_valid", 32'(valid), 32'd0);
      check("rst_ferr", 32'(framing_err), 32'd0);
      check("rst_ovr", 32'(overrun), 32'd0);
      idle(4);

      // 1: single byte, ready high, latency
      ready = 1'b1;
      v0 = valid_cycles; f0 = ferr_cnt; o0 = ovr_cnt;
      send_frame(8'h41, 1'b1, 1'b1, -1);
      idle(4);
      check("t1_latency", 32'(rise_cyc - fall_cyc), 32'(LAT));
      check("t1_valid_cycles", 32'(valid_cycles - v0), 32'd1);
      check("t1_ferr", 32'(ferr_cnt - f0), 32'd0);
      check("t1_ovr", 32'(ovr_cnt - o0), 32'd0);

      // 2: hold with ready low, then one-cycle accept
      ready = 1'b0;
      send_frame(8'h48, 1'b1, 1'b1, -1);
      idle(100);
      @(negedge clk);
      check("t2_hold_valid", 32'(valid), 32'd1);
      check("t2_hold_data", 32'(data), 32'h48);
      tick(); ready = 1'b1;
      tick(); ready = 1'b0;
      @(negedge clk);
      check("t2_released", 32'(valid), 32'd0);

      // 3: overrun, second byte dropped
      o0 = ovr_cnt;
      send_frame(8'h31, 1'b1, 1'b1, -1);
      send_frame(8'h32, 1'b1, 1'b0, -1);
      idle(3);
      @(negedge clk);
      check("t3_ovr_pulses", 32'(ovr_cnt - o0), 32'd1);
      check("t3_held_data", 32'(data), 32'h31);
      check("t3_held_valid", 32'(valid), 32'd1);
      tick(); ready = 1'b1;
      tick(); ready = 1'b0;
      idle(20);
      @(negedge clk);
      check("t3_no_second", 32'(valid), 32'd0);
      check("t3_queue_empty", 32'(exp_q.size()), 32'd0);

      // 4: framing error, long low, then clean byte
      ready = 1'b1;
      v0 = valid_cycles; f0 = ferr_cnt;
      send_frame(8'h55, 1'b0, 1'b0, -1);
      idle(40);
      rx = 1'b1;
      idle(10);
      check("t4_ferr_pulses", 32'(ferr_cnt - f0), 32'd1);
      check("t4_no_valid", 32'(valid_cycles - v0), 32'd0);
      send_frame(8'h0D, 1'b1, 1'b1, -1);
      idle(10);
      check("t4_received", 32'(exp_q.size()), 32'd0);
      check("t4_ferr_once", 32'(ferr_cnt - f0), 32'd1);

      // 5: glitch shorter than HALF, then back-to-back with toggling ready
      v0 = valid_cycles; f0 = ferr_cnt; o0 = ovr_cnt;
      rx = 1'b0;
      idle(3);
      rx = 1'b1;
      idle(30);
      check("t5_glitch_no_valid", 32'(valid_cycles - v0), 32'd0);
      check("t5_glitch_no_ferr", 32'(ferr_cnt - f0), 32'd0);
      ready = 1'b0;
      toggle_rdy = 1'b1;
      send_frame(8'h1B, 1'b1, 1'b1, -1);
      send_frame(8'h48, 1'b1, 1'b1, -1);
      idle(10);
      toggle_rdy = 1'b0;
      ready = 1'b1;
      idle(4);
      check("t5_no_ovr", 32'(ovr_cnt - o0), 32'd0);
      check("t5_delivered", 32'(exp_q.size()), 32'd0);

      // 6: clr mid-frame with a pending byte, then clean frame
      ready = 1'b0;
      send_frame(8'hC3, 1'b1, 1'b0, -1);
      idle(4);
      @(negedge clk);
      check("t6_pending", 32'(valid), 32'd1);
      // Bits 4..7 of 0xF0 are high, so the tail of the aborted frame is idle line.
      send_frame(8'hF0, 1'b1, 1'b0, 5);
      idle(20);
      @(negedge clk);
      check("t6_no_tail_byte", 32'(valid), 32'd0);
      ready = 1'b1;
      send_frame(8'h7E, 1'b1, 1'b1, -1);
      idle(10);
      check("t6_received", 32'(exp_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
